// File: rtl/dc_int_svc.sv
// DC interrupt service sequencer: reads the DC interrupt register, reports bus
// events, then reads and streams the status of every pending endpoint in order.
module dc_int_svc #(
  parameter logic [7:0] INT_RD_CMD = 8'hC0,
  parameter logic [7:0] EP_ST_BASE = 8'h50,
  parameter int         TIMEOUT    = 1023
) (
  input  logic        I_CLK,
  input  logic        I_RSTF,
  input  logic        I_EN,
  input  logic        I_DC_INT1,
  output logic        O_START,
  output logic        O_READ,
  output logic [7:0]  O_REG_ADDR,
  output logic [5:0]  O_REG_WORDS,
  input  logic        I_DONE,
  input  logic [31:0] I_RDATA,
  output logic        O_EVT_VALID,
  input  logic        I_EVT_READY,
  output logic [3:0]  O_EVT_EP,
  output logic [7:0]  O_EVT_STAT,
  output logic [2:0]  O_BUS_EVT,
  output logic        O_ERR,
  output logic        O_BUSY
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, RD_INT, WAIT_INT, SCAN, RD_EP, WAIT_EP, EMIT} state_t;

  state_t        state, state_nxt;
  logic          int_s1, int_s2;
  logic [13:0]   pending;
  logic [3:0]    cur_ep, lsb;
  logic [CW-1:0] cnt;
  logic          timeout;
  logic          unused_rdata;

  assign unused_rdata = ^{I_RDATA[31:22], I_RDATA[7:3]};
  assign timeout      = (cnt == TO_LAST) && !I_DONE;

  // lowest pending endpoint wins, giving ascending service order
  always_comb begin
    lsb = '0;
    for (int i = 13; i >= 0; i--)
      if (pending[i]) lsb = 4'(i);
  end

  always_comb begin
    state_nxt   = state;
    O_START     = 1'b0;
    O_READ      = 1'b0;
    O_EVT_VALID = 1'b0;
    O_BUSY      = (state != IDLE);
    case (state)
      IDLE:     if (I_EN && int_s2) state_nxt = RD_INT;
      RD_INT: begin
        O_START   = 1'b1;
        O_READ    = 1'b1;
        state_nxt = WAIT_INT;
      end
      WAIT_INT: begin
        O_READ = 1'b1;
        if (I_DONE)       state_nxt = SCAN;
        else if (timeout) state_nxt = IDLE;
      end
      SCAN:     state_nxt = (pending == '0) ? IDLE : RD_EP;
      RD_EP: begin
        O_START   = 1'b1;
        O_READ    = 1'b1;
        state_nxt = WAIT_EP;
      end
      WAIT_EP: begin
        O_READ = 1'b1;
        if (I_DONE)       state_nxt = EMIT;
        else if (timeout) state_nxt = IDLE;
      end
      EMIT: begin
        O_EVT_VALID = 1'b1;
        if (I_EVT_READY) state_nxt = SCAN;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (!I_RSTF) begin
      state       <= IDLE;
      int_s1      <= 1'b0;
      int_s2      <= 1'b0;
      pending     <= '0;
      cur_ep      <= '0;
      cnt         <= '0;
      O_REG_ADDR  <= '0;
      O_REG_WORDS <= '0;
      O_EVT_EP    <= '0;
      O_EVT_STAT  <= '0;
      O_BUS_EVT   <= '0;
      O_ERR       <= 1'b0;
    end else begin
      int_s1    <= I_DC_INT1;
      int_s2    <= int_s1;
      state     <= state_nxt;
      O_BUS_EVT <= '0;
      O_ERR     <= 1'b0;
      case (state)
        IDLE: if (state_nxt == RD_INT) begin
          O_REG_ADDR  <= INT_RD_CMD;
          O_REG_WORDS <= 6'd2;
        end
        RD_INT, RD_EP: cnt <= '0;
        WAIT_INT: begin
          if (I_DONE) begin
            pending   <= I_RDATA[21:8];
            O_BUS_EVT <= I_RDATA[2:0];
          end else if (timeout) begin
            O_ERR   <= 1'b1;
            pending <= '0;
          end else cnt <= cnt + 1'b1;
        end
        SCAN: if (pending != '0) begin
          pending[lsb] <= 1'b0;
          cur_ep       <= lsb;
          O_REG_ADDR   <= EP_ST_BASE + {4'd0, lsb};
          O_REG_WORDS  <= 6'd1;
        end
        WAIT_EP: begin
          if (I_DONE) begin
            O_EVT_EP   <= cur_ep;
            O_EVT_STAT <= I_RDATA[7:0];
          end else if (timeout) begin
            O_ERR   <= 1'b1;
            pending <= '0;
          end else cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dc_int_svc.sv
// Directed bench for dc_int_svc: table of interrupt words plus hand-built
// sequences for back-pressure, timeout, reset abandonment and enable gating.
module tb_dc_int_svc;
  localparam int TO = 1023;

  logic        I_CLK = 1'b0;
  logic        I_RSTF, I_EN, I_DC_INT1, I_DONE, I_EVT_READY;
  logic [31:0] I_RDATA;
  logic        O_START, O_READ, O_EVT_VALID, O_ERR, O_BUSY;
  logic [7:0]  O_REG_ADDR, O_EVT_STAT;
  logic [5:0]  O_REG_WORDS;
  logic [3:0]  O_EVT_EP;
  logic [2:0]  O_BUS_EVT;

  int tests = 0;
  int fails = 0;

  dc_int_svc #(.INT_RD_CMD(8'hC0), .EP_ST_BASE(8'h50), .TIMEOUT(TO)) dut (
    .I_CLK(I_CLK), .I_RSTF(I_RSTF), .I_EN(I_EN), .I_DC_INT1(I_DC_INT1),
    .O_START(O_START), .O_READ(O_READ), .O_REG_ADDR(O_REG_ADDR),
    .O_REG_WORDS(O_REG_WORDS), .I_DONE(I_DONE), .I_RDATA(I_RDATA),
    .O_EVT_VALID(O_EVT_VALID), .I_EVT_READY(I_EVT_READY), .O_EVT_EP(O_EVT_EP),
    .O_EVT_STAT(O_EVT_STAT), .O_BUS_EVT(O_BUS_EVT), .O_ERR(O_ERR), .O_BUSY(O_BUSY)
  );

  always #10 I_CLK = ~I_CLK;

  typedef struct {
    logic [31:0] int_word;
    logic [2:0]  exp_bus;
    logic [13:0] exp_mask;
    logic [7:0]  stat_base;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_ctl"}, 32'({O_START, O_READ, O_REG_ADDR, O_REG_WORDS, O_EVT_VALID, O_ERR, O_BUSY}), 32'd0);
    chk({name, "_evt"}, 32'({O_EVT_EP, O_EVT_STAT, O_BUS_EVT}), 32'd0);
  endtask

  // Waits for a request, checks it, holds it `dly` cycles, then answers with data.
  task automatic do_read(input logic [7:0] ea, input logic [5:0] ew, input logic [31:0] d,
                         input int dly, input bit drop_int);
    int k = 0;
    while (!O_START && k < 50) begin tick(); k++; end
    chk("start_seen", 32'(O_START), 32'd1);
    if (!O_START) return;
    if (drop_int) I_DC_INT1 = 1'b0;
    chk("req_addr", 32'(O_REG_ADDR), 32'(ea));
    chk("req_words", 32'(O_REG_WORDS), 32'(ew));
    chk("req_read", 32'(O_READ), 32'd1);
    tick();
    chk("start_one_cycle", 32'(O_START), 32'd0);
    for (int i = 0; i < dly; i++) begin
      chk("addr_stable", 32'({O_READ, O_REG_WORDS, O_REG_ADDR}), 32'({1'b1, ew, ea}));
      tick();
    end
    chk("addr_at_done", 32'({O_READ, O_REG_WORDS, O_REG_ADDR}), 32'({1'b1, ew, ea}));
    I_DONE = 1'b1; I_RDATA = d;
    tick();
    I_DONE = 1'b0; I_RDATA = '0;
  endtask

  task automatic expect_evt(input logic [3:0] ep, input logic [7:0] st);
    int k = 0;
    while (!O_EVT_VALID && k < 50) begin tick(); k++; end
    chk("evt_valid", 32'(O_EVT_VALID), 32'd1);
    chk("evt_ep", 32'(O_EVT_EP), 32'(ep));
    chk("evt_stat", 32'(O_EVT_STAT), 32'(st));
    tick();
    chk("evt_valid_drop", 32'(O_EVT_VALID), 32'd0);
  endtask

  task automatic expect_idle(input int n);
    bit seen = 0;
    for (int i = 0; i < n; i++) begin
      if (O_START || O_EVT_VALID) seen = 1;
      tick();
    end
    chk("no_extra_activity", 32'(seen), 32'd0);
    chk("busy_idle", 32'(O_BUSY), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    I_DC_INT1 = 1'b1;
    do_read(8'hC0, 6'd2, v.int_word, 1, 1'b1);
    chk("bus_evt", 32'(O_BUS_EVT), 32'(v.exp_bus));
    tick();
    chk("bus_evt_pulse", 32'(O_BUS_EVT), 32'd0);
    for (int n = 0; n < 14; n++) begin
      if (v.exp_mask[n]) begin
        do_read(8'(8'h50 + n), 6'd1, 32'(8'(v.stat_base + n)), 0, 1'b0);
        expect_evt(4'(n), 8'(v.stat_base + n));
      end
    end
    expect_idle(4);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0000_0005, 3'b101, 14'h0000, 8'h10};
    vecs[1] = '{32'h0000_0500, 3'b000, 14'h0005, 8'h30};
    vecs[2] = '{32'hFFC0_00F8, 3'b000, 14'h0000, 8'h40};
    vecs[3] = '{32'h003F_FF02, 3'b010, 14'h3FFF, 8'h80};
    vecs[4] = '{32'h0020_0103, 3'b011, 14'h2001, 8'hA0};
    vecs[5] = '{32'h0001_2404, 3'b100, 14'h0124, 8'hC0};

    I_RSTF = 1'b0; I_EN = 1'b1; I_DC_INT1 = 1'b1; I_DONE = 1'b0;
    I_RDATA = '0; I_EVT_READY = 1'b1;
    repeat (3) tick();
    chk_zero("reset");
    I_DC_INT1 = 1'b0;
    I_RSTF = 1'b1;
    tick();

    // two endpoints, enable dropped mid-sequence must not stop it
    I_DC_INT1 = 1'b1;
    do_read(8'hC0, 6'd2, 32'h0000_0500, 2, 1'b1);
    I_EN = 1'b0;
    do_read(8'h50, 6'd1, 32'h0000_0021, 1, 1'b0);
    expect_evt(4'd0, 8'h21);
    do_read(8'h52, 6'd1, 32'h0000_0042, 0, 1'b0);
    expect_evt(4'd2, 8'h42);
    expect_idle(4);
    I_EN = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // event back-pressure for 10 cycles
    I_DC_INT1 = 1'b1;
    I_EVT_READY = 1'b0;
    do_read(8'hC0, 6'd2, 32'h0000_0300, 0, 1'b1);
    do_read(8'h50, 6'd1, 32'h0000_0011, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("hold_evt", 32'({O_START, O_EVT_VALID, O_EVT_EP, O_EVT_STAT}), 32'({1'b0, 1'b1, 4'd0, 8'h11}));
      tick();
    end
    I_EVT_READY = 1'b1;
    tick();
    chk("hold_released", 32'(O_EVT_VALID), 32'd0);
    do_read(8'h51, 6'd1, 32'h0000_0022, 0, 1'b0);
    expect_evt(4'd1, 8'h22);
    expect_idle(4);

    // bus timeout on the interrupt read
    begin
      int k = 0;
      I_DC_INT1 = 1'b1;
      while (!O_START && k < 50) begin tick(); k++; end
      chk("to_start", 32'(O_START), 32'd1);
      I_DC_INT1 = 1'b0;
      tick();
      k = 0;
      while (!O_ERR && k < TO + 10) begin tick(); k++; end
      chk("to_err_latency", 32'(k), 32'(TO));
      chk("to_idle", 32'(O_BUSY), 32'd0);
      tick();
      chk("to_err_pulse", 32'(O_ERR), 32'd0);
      expect_idle(3);
    end

    // reset while waiting for endpoint status, then a stray done
    begin
      int k = 0;
      I_DC_INT1 = 1'b1;
      do_read(8'hC0, 6'd2, 32'h0000_0100, 0, 1'b1);
      while (!O_START && k < 50) begin tick(); k++; end
      chk("rst_ep_addr", 32'(O_REG_ADDR), 32'h50);
      tick();
      chk("rst_in_wait", 32'({O_BUSY, O_READ}), 32'd3);
      I_RSTF = 1'b0;
      tick();
      chk_zero("mid_reset");
      I_RSTF = 1'b1;
      I_DONE = 1'b1; I_RDATA = 32'h0000_00AA;
      tick();
      I_DONE = 1'b0; I_RDATA = '0;
      expect_idle(5);
    end

    // enable gating with interrupt pending
    I_EN = 1'b0;
    I_DC_INT1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("en_block", 32'({O_START, O_BUSY}), 32'd0);
      tick();
    end
    I_EN = 1'b1;
    tick();
    chk("en_start", 32'({O_START, O_REG_ADDR}), 32'({1'b1, 8'hC0}));
    do_read(8'hC0, 6'd2, 32'h0000_0000, 0, 1'b1);
    expect_idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dc_int_svc.md
DC_INT_SVC -- requirements
Module: dc_int_svc

Interface
REQ-001 SHALL have parameter INT_RD_CMD, default 8'hC0, command code that reads the 32-bit DC interrupt register.
REQ-002 SHALL have parameter EP_ST_BASE, default 8'h50, status-read command for endpoint 0; endpoint n uses EP_ST_BASE+n.
REQ-003 SHALL have parameter TIMEOUT, default 1023, max cycles to wait for bus done.
REQ-004 SHALL have ports: I_CLK in 1 clock 50 MHz; I_RSTF in 1 reset.
REQ-005 I_CLK is the only clock; I_RSTF is synchronous and active-low.
REQ-006 I_EN in 1: service enable.
REQ-007 I_DC_INT1 in 1: DC interrupt, active-high level, asynchronous.
REQ-008 O_START out 1: single-cycle bus transfer request to the bus interface.
REQ-009 O_READ out 1: read transfer, always 1 while a request is held.
REQ-010 O_REG_ADDR out 8: command code; O_REG_WORDS out 6: word count.
REQ-011 I_DONE in 1: one-cycle transfer completion from the bus interface.
REQ-012 I_RDATA in 32: read data, valid in the I_DONE cycle, word0 in [15:0].
REQ-013 O_EVT_VALID out 1, I_EVT_READY in 1, O_EVT_EP out 4, O_EVT_STAT out 8: endpoint event stream.
REQ-014 O_BUS_EVT out 3: one-cycle pulses {resume, suspend, bus reset}.
REQ-015 O_ERR out 1: one-cycle timeout pulse; O_BUSY out 1: state != IDLE.

Function
REQ-016 SHALL synchronise I_DC_INT1 through two flops; only the synchronised level is used.
REQ-017 States: IDLE, RD_INT, WAIT_INT, SCAN, RD_EP, WAIT_EP, EMIT.
REQ-018 IDLE -> RD_INT when I_EN=1 and synchronised INT1=1.
REQ-019 RD_INT: O_START=1 for exactly one cycle with O_REG_ADDR=INT_RD_CMD and O_REG_WORDS=2; next state WAIT_INT.
REQ-020 O_REG_ADDR, O_REG_WORDS, and O_READ SHALL stay stable from the O_START cycle through the I_DONE cycle.
REQ-021 WAIT_INT, on I_DONE:
- capture pending[13:0] = I_RDATA[21:8];
- pulse O_BUS_EVT = I_RDATA[2:0] for one cycle;
- go to SCAN.
REQ-022 SCAN: if pending==0, go to IDLE; else select n = lowest set bit of pending, clear that bit, go to RD_EP.
REQ-023 RD_EP: one-cycle O_START with O_REG_ADDR=EP_ST_BASE+n and O_REG_WORDS=1; next state WAIT_EP.
REQ-024 WAIT_EP, on I_DONE: latch O_EVT_EP=n and O_EVT_STAT=I_RDATA[7:0]; go to EMIT.
REQ-025 EMIT:
- O_EVT_VALID=1;
- EP/STAT stable until the I_EVT_READY=1 cycle;
- then VALID drops next cycle and state returns to SCAN.
REQ-026 Wait counter:
- cleared on entry to WAIT_INT or WAIT_EP;
- increments each cycle while waiting;
- reaching TIMEOUT without I_DONE pulses O_ERR, clears pending, goes to IDLE.
REQ-027 I_DONE outside WAIT_INT/WAIT_EP SHALL be ignored.
REQ-028 I_EN=0 SHALL only block IDLE exit; an in-progress sequence completes.
REQ-029 Minimum latency from sync INT1 high in IDLE to O_START: 1 cycle (RD_INT entered next edge, O_START asserted in it).
REQ-030 After returning to IDLE with INT1 still high, a new sequence SHALL start; there is no extra holdoff.
REQ-031 Endpoint bits are serviced in ascending order, one bus read each; 14 set bits give 14 events.
REQ-032 Interrupt bits [7:3] and [31:22] SHALL be ignored.

Reset
REQ-033 On I_RSTF=0 at a clock edge:
- state returns to IDLE;
- sync flops, pending, wait counter, O_START, O_EVT_VALID, O_BUS_EVT, O_ERR, O_BUSY are cleared;
- O_REG_ADDR, O_REG_WORDS, O_EVT_EP, O_EVT_STAT, O_READ are 0.
REQ-034 Reset mid-operation SHALL abandon the sequence with no event emitted.

Verification
REQ-035 INT1 high, I_RDATA=32'h0000_0500 on first done, status 8'h21 for EP0, 8'h42 for EP2, ready=1, INT1 low after the int read:
- two-word read of 8'hC0;
- then reads of 8'h50 and 8'h52;
- events (0,21h) then (2,42h);
- then IDLE.
REQ-036 Interrupt data 32'h0000_0005 -> O_BUS_EVT=3'b101 for one cycle, no endpoint reads, return to IDLE.
REQ-037 EMIT with I_EVT_READY low 10 cycles -> VALID/EP/STAT held constant; next read issued only after the handshake.
REQ-038 No I_DONE after O_START -> O_ERR pulses exactly TIMEOUT cycles after WAIT entry; state IDLE.
REQ-039 Reset asserted in WAIT_EP -> all outputs 0 next edge; spurious I_DONE afterwards produces no event.
REQ-040 I_EN=0 with INT1 high -> no O_START; raise I_EN -> RD_INT next cycle.
